// File: rtl/lsu_pkg.sv
// Shared types for the MEM-stage load/store controller: size codes,
// FSM states and the alignment rule.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE_WR,
        FAULT
    } lsu_state_t;

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] addr_lo
    );
        return (size == SZ_HALF && addr_lo[0])
            || (size == SZ_WORD && addr_lo != 2'b00)
            || (size == 2'b11);
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Pipeline-side request bundle and word-wide data memory port
// used by the load/store controller.
interface lsu_req_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic              sext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              done;
    logic              err;
    logic [31:0]       rdata;

    modport master (
        output req, wr, size, sext, addr, wdata,
        input  ready, done, err, rdata
    );
    modport slave (
        input  req, wr, size, sext, addr, wdata,
        output ready, done, err, rdata
    );
endinterface

interface lsu_mem_if #(
    parameter int ADDR_W = 32
);
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wd;
    logic [31:0]       rd;

    modport master (
        output wr, addr, wd,
        input  rd
    );
    modport slave (
        input  wr, addr, wd,
        output rd
    );
endinterface

// File: rtl/lsu_lane.sv
// Little-endian byte/half lane logic: extended load extraction and
// store merge into an existing word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] i_rd,
    input  logic [31:0] i_wd,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);
    logic [4:0]  w_bsh;
    logic [4:0]  w_hsh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_bmask;
    logic [31:0] w_hmask;

    assign w_bsh   = {i_addr_lo, 3'b000};
    assign w_hsh   = {i_addr_lo[1], 4'b0000};
    assign w_byte  = i_rd[w_bsh +: 8];
    assign w_half  = i_rd[w_hsh +: 16];
    assign w_bmask = 32'h0000_00FF << w_bsh;
    assign w_hmask = 32'h0000_FFFF << w_hsh;

    always_comb begin
        o_load   = i_rd;
        o_merged = i_wd;
        unique case (1'b1)
            (i_size == SZ_BYTE): begin
                o_load   = {{24{i_sext & w_byte[7]}}, w_byte};
                o_merged = (i_rd & ~w_bmask)
                         | ({24'b0, i_wd[7:0]} << w_bsh);
            end
            (i_size == SZ_HALF): begin
                o_load   = {{16{i_sext & w_half[15]}}, w_half};
                o_merged = (i_rd & ~w_hmask)
                         | ({16'b0, i_wd[15:0]} << w_hsh);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store controller; sub-word stores use read-modify-write.
// Define LSU_TRACE_EN to log every memory write as "*addr <= data".
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic        i_clk,
    input logic        i_rst_n,
    lsu_req_if.slave   req_if,
    lsu_mem_if.master  mem_if
);
    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr;
    logic [1:0]        r_size;
    logic              r_sext;
    logic [31:0]       r_wdata;
    logic [31:0]       r_merge;
    logic [31:0]       r_rdata;
    logic              r_done;
    logic              r_err;
    logic              w_bad;
    logic              w_sub;
    logic [31:0]       w_lane_rd;
    logic [31:0]       w_load;
    logic [31:0]       w_merged;

    assign w_bad = is_misaligned(req_if.size, req_if.addr[1:0]);
    assign w_sub = r_wr && (r_size != SZ_WORD);

    // The merge pass works on the captured word, not the live bus.
    assign w_lane_rd = (r_state == MERGE_WR) ? r_merge : mem_if.rd;

    lsu_lane u_lane (
        .i_rd      (w_lane_rd),
        .i_wd      (r_wdata),
        .i_addr_lo (r_addr[1:0]),
        .i_size    (r_size),
        .i_sext    (r_sext),
        .o_load    (w_load),
        .o_merged  (w_merged)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_size  <= SZ_BYTE;
            r_sext  <= 1'b0;
            r_wdata <= '0;
            r_merge <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (req_if.req) begin
                        r_addr  <= req_if.addr;
                        r_wr    <= req_if.wr;
                        r_size  <= req_if.size;
                        r_sext  <= req_if.sext;
                        r_wdata <= req_if.wdata;
                    end
                end
                ACCESS: begin
                    if (!r_wr) r_rdata <= w_load;
                    if (w_sub) r_merge <= mem_if.rd;
                    r_done <= !w_sub;
                end
                MERGE_WR: r_done <= 1'b1;
                FAULT: begin
                    r_done <= 1'b1;
                    r_err  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next      = r_state;
        mem_if.wr   = 1'b0;
        mem_if.addr = '0;
        mem_if.wd   = '0;
        unique case (r_state)
            IDLE: begin
                if (req_if.req) w_next = w_bad ? FAULT : ACCESS;
            end
            ACCESS: begin
                mem_if.addr = {r_addr[ADDR_W-1:2], 2'b00};
                if (r_wr && !w_sub) begin
                    mem_if.wr = 1'b1;
                    mem_if.wd = r_wdata;
                end
                w_next = w_sub ? MERGE_WR : IDLE;
            end
            MERGE_WR: begin
                mem_if.addr = {r_addr[ADDR_W-1:2], 2'b00};
                mem_if.wr   = 1'b1;
                mem_if.wd   = w_merged;
                w_next      = IDLE;
            end
            FAULT: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign req_if.ready = (r_state == IDLE);
    assign req_if.done  = r_done;
    assign req_if.err   = r_err;
    assign req_if.rdata = r_rdata;

`ifdef LSU_TRACE_EN
    always @(posedge i_clk) begin
        if (mem_if.wr) $display("*%h <= %h", mem_if.addr, mem_if.wd);
    end
`else
`endif

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller for the MEM stage. It is the initiator that drives the word-wide data memory port: single-cycle write enable, word address, write data, and combinational read data. It accepts byte, halfword and word loads and stores from the pipeline. Sub-word stores are done as a read-modify-write over the word-only memory. Loads are extracted and sign- or zero-extended. Misaligned accesses are flagged and never reach memory.

## Interface
Parameters:
- ADDR_W, 32, byte-address width on both sides.

Ports:
- Clk  in  1  sole clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  1  access request; sampled only while Ready=1.
- Wr  in  1  1 = store, 0 = load.
- Size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned).
- SignExt  in  1  loads only: 1 sign-extend, 0 zero-extend.
- Addr  in  ADDR_W  byte address.
- WData  in  32  store data; byte/half taken from low bits.
- Ready  out  1  controller idle, Req will be accepted.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  valid with Done: misaligned/reserved access, no memory effect.
- RData  out  32  extended load data, valid with Done on loads.
- MemWr  out  1  memory write enable.
- MemAddr  out  ADDR_W  word-aligned address, low two bits always 0.
- MemWD  out  32  memory write data.
- MemRD  in  32  memory read data, combinational from MemAddr.

## Operation
- Byte lanes are little-endian: Addr[1:0]=0 selects bits 7:0, and 3 selects bits 31:24. A halfword at Addr[1]=1 occupies bits 31:16.
- Request registers capture Addr, Wr, Size, SignExt and WData on the accepting edge.
- States:
  - IDLE: Ready=1. Req=1 moves to ACCESS, or to FAULT if misaligned.
  - ACCESS: MemAddr={addr[ADDR_W-1:2],2'b00}.
    - Load: register the extended lane of MemRD, then go to IDLE.
    - Word store: MemWr=1 with MemWD=WData, then go to IDLE.
    - Sub-word store: capture MemRD into the merge register, then go to MERGE_WR.
  - MERGE_WR: MemWr=1. MemWD is the merge register with the target lane(s) replaced by WData. Then go to IDLE.
  - FAULT: MemWr=0, then go to IDLE with Err.
- Misaligned means Size=01 with Addr[0]=1, Size=10 with Addr[1:0]≠0, or Size=11.
- Done is registered and pulses in the first IDLE cycle after the final state. Err=1 is asserted with that pulse only for a fault.
- RData holds its value until the next load completes.
- MemWr is decoded from state only, never from Req.
- Req while Ready=0 is ignored; the pipeline holds Req until accepted.

## Timing
- Reset asserted: state=IDLE; Ready=1; Done=0, Err=0, RData=0, MemWr=0, MemAddr=0, MemWD=0. This takes effect immediately, mid-operation included. A pending MERGE_WR write is abandoned and memory is left untouched.
- Let cycle 0 be the accepting edge.
- Load: memory read in cycle 1; Done and RData in cycle 2.
- Word store: MemWr in cycle 1; Done in cycle 2.
- Sub-word store: read in cycle 1, MemWr in cycle 2; Done in cycle 3.
- Fault: Done with Err=1 in cycle 2; MemWr never asserted.
- Back-to-back requests: a Req present during the Done cycle is accepted on that edge, giving a zero-bubble restart.

## Configuration
- LSU_TRACE_EN defined: every cycle with MemWr=1 prints one line via $display in the form "*%h <= %h", giving MemAddr and MemWD.
- Not defined: no simulation output; RTL otherwise identical.

## Structure
- lsu_pkg holds:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum IDLE/ACCESS/MERGE_WR/FAULT.
  - Function is_misaligned(size, addr_lo).
- One combinational sub-module, lsu_lane. It takes MemRD, WData, Addr[1:0], Size and SignExt, and produces the extended load word and the merged store word. The FSM stays in lsu_ctrl.

## Test plan
- Reset, then word load at 0x10 with mem[0x10]=0x8899AABB -> Done in cycle 2, RData=0x8899AABB, Err=0.
- Byte load at 0x13, same word, SignExt=1 -> RData=0xFFFFFF88. With SignExt=0 -> RData=0x00000088.
- Byte store at 0x11, WData=0x000000CC -> single MemWr in cycle 2 with MemAddr=0x10 and MemWD=0x8899CCBB; Done in cycle 3.
- Half store at 0x11 -> Done with Err=1 in cycle 2, MemWr stays 0, mem[0x10] unchanged. Size=11 gives the same result.
- Reset driven low during MERGE_WR -> MemWr drops at once, mem[0x10] keeps its old value, Ready=1 after release.
- Word store 0x12345678 at 0x20, then back-to-back load from 0x20 accepted in the store's Done cycle -> RData=0x12345678. With LSU_TRACE_EN, the log contains "*00000020 <= 12345678".
